dl11_fifo_bridge: RTL and testbench
===================================

// Module: dl11_fifo_bridge
// PURPOSE
//  Parametrised multi-channel DL11-style serial register bank between the DCJ11 bus and the Apple II host.
//  Each channel has an RX FIFO (Apple->PDP) and a TX FIFO (PDP->Apple) instead of single-byte buffers.
//  Per-channel interrupt enables and overrun error flags are provided.
//  Sits behind the DCJ11 bus decoder (cycle strobes) and the Apple II /DEVSEL synchroniser.
// PARAMETERS
//  NCHAN       1          number of channels, 1..4
//  FIFO_DEPTH  16         entries per FIFO, power of 2, 2..256
//  CONS_BASE   22'o17777560  channel 0 RCSR address (console)
//  EXT_BASE    22'o17776500  channel n>=1 RCSR address = EXT_BASE + 8*(n-1)
// PORTS
//  clk        in   1      system clock
//  rst_n      in   1      async active-low reset
//  cpu_init   in   1      sync bus INIT (GP code 014), one-cycle pulse
//  cpu_addr   in   22     latched physical address of current bus cycle
//  cpu_rd     in   1      one-cycle read strobe, BS=EXT
//  cpu_wr     in   1      one-cycle write strobe, BS=EXT
//  cpu_byte   in   1      byte write qualifier
//  cpu_wdata  in   16     write data
//  cpu_rdata  out  16     read data, valid while cpu_hit
//  cpu_hit    out  1      cpu_addr decodes to a register of this block, so NXM is suppressed
//  a2_strb    in   1      one-cycle Apple access strobe, already synchronised
//  a2_rw      in   1      1 = Apple read, 0 = Apple write
//  a2_addr    in   4      [3:2] channel, [1:0] register
//  a2_wdata   in   8      Apple write data
//  a2_rdata   out  8      Apple read data, registered
//  rx_irq     out  NCHAN  per-channel receiver interrupt request, level
//  tx_irq     out  NCHAN  per-channel transmitter interrupt request, level
// BEHAVIOUR
//  Reset (rst_n=0) and cpu_init act identically (init is synchronous):
//   - all FIFOs empty; IE bits 0; overrun 0
//   - a2_rdata=0; rx_irq=0; tx_irq=0
//  cpu_hit/cpu_rdata are combinational from cpu_addr; cpu_rdata=0 when not hit or the register is unimplemented.
//  CPU register map, relative to the channel base:
//   +0 RCSR: [7] DONE = RX FIFO not empty (RO); [6] RIE (RW); other bits read 0
//   +2 RBUF: [15] ERR = OR of [14]; [14] OVR; [7:0] RX head byte (0 if empty)
//        - cpu_rd pops the RX FIFO and clears OVR; pop on empty is ignored
//   +4 XCSR: [7] READY = TX FIFO not full (RO); [6] XIE (RW); other bits read 0
//   +6 XBUF: write pushes cpu_wdata[7:0] (word or byte write); reads 0
//        - write while full: byte dropped, no flag
//  Apple map per channel (a2_addr[1:0]); a2_rdata loads 1 cycle after a2_strb and holds until the next read:
//   0 STAT: read {TXAV, RXFULL, OVR, 5'b0}; TXAV = TX not empty
//   1 TXD:  read returns TX head and pops it (0 if empty); write ignored
//   2 RXD:  write pushes a2_wdata; if RX full the byte is dropped and OVR is set (sticky)
//   3 LVL:  read returns TX occupancy count, saturated to 8 bits
//  Channel fields with index >= NCHAN: reads 0, writes ignored, cpu_hit=0.
//  FIFOs:
//   - push or pop takes effect at the clock edge; the new head is visible next cycle
//   - simultaneous push+pop is legal at any level; count unchanged; accepted even when full
//   - pointers wrap modulo FIFO_DEPTH; count has log2(FIFO_DEPTH)+1 bits
//  Interrupts: rx_irq[n] = RIE & DONE; tx_irq[n] = XIE & READY; registered, 1-cycle latency.
//  Simultaneous CPU and Apple strobes on the same channel are both serviced in the same cycle.
//  cpu_init coincident with a push: init wins and the FIFO ends empty.
//  Writes to RCSR/XCSR change only bit 6.
//   - cpu_byte write to an odd address (high byte) leaves IE unchanged
// STRUCTURE
//  dl11_pkg: register offsets (RCSR/RBUF/XCSR/XBUF), bit positions DONE/READY/IE/OVR/ERR, Apple register codes.
//  Sub-module byte_fifo (params DEPTH; ports clk, rst_n, clr, push, din, pop, dout, empty, full, count).
//   - two instances per channel, generated over NCHAN
// TESTING
//  T1 reset: rst_n pulse -> RCSR=0, XCSR=0o200, rx_irq=0, tx_irq=0, STAT=0x00.
//  T2 Apple RX: write RXD 0x41,0x42 on ch0 -> RCSR=0o200, RBUF=0x41; after RBUF read -> 0x42; after the next read, RCSR=0.
//  T3 overrun: 17 RXD writes with DEPTH=16 -> STAT=0x60; RBUF=0o140000|first byte; OVR clears on the RBUF read.
//  T4 TX full: 16 XBUF writes to 0o17777566 -> XCSR READY=0, LVL=16; one TXD pop -> READY=1 next cycle.
//  T5 interrupts/channels: NCHAN=2; set RIE at 0o17776500; Apple writes ch1 RXD -> rx_irq=2'b10 within 2 cycles.
//   - access 0o17776510 -> cpu_hit=0
//  T6 concurrency/init: push+pop the same cycle when full -> count stays 16; cpu_init mid-burst -> all empty, IE=0.

Source files
------------

// File: rtl/dl11_pkg.sv
// Shared register offsets, bit positions and Apple register codes for the DL11 FIFO bridge.
// chan_base() gives each channel's RCSR address: the console slot first, then the extended block.
package dl11_pkg;

  // CPU register select is the word index within a channel (cpu_addr[2:1])
  localparam logic [1:0] CPU_RCSR = 2'd0;
  localparam logic [1:0] CPU_RBUF = 2'd1;
  localparam logic [1:0] CPU_XCSR = 2'd2;
  localparam logic [1:0] CPU_XBUF = 2'd3;

  localparam int BIT_DONE  = 7;
  localparam int BIT_READY = 7;
  localparam int BIT_IE    = 6;
  localparam int BIT_OVR   = 14;
  localparam int BIT_ERR   = 15;

  localparam logic [1:0] A2_STAT = 2'd0;
  localparam logic [1:0] A2_TXD  = 2'd1;
  localparam logic [1:0] A2_RXD  = 2'd2;
  localparam logic [1:0] A2_LVL  = 2'd3;

  function automatic logic [21:0] chan_base(input int n, input logic [21:0] cons,
                                            input logic [21:0] ext);
    if (n == 0) return cons;
    return ext + 22'(8 * (n - 1));
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// Byte-wide circular FIFO with synchronous clear; a pop frees room for a same-cycle push,
// so push+pop on a full FIFO is accepted and leaves the count unchanged.
module byte_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_clr,
  input  logic                     i_push,
  input  logic [7:0]               i_din,
  input  logic                     i_pop,
  output logic [7:0]               o_dout,
  output logic                     o_empty,
  output logic                     o_full,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic          w_push;
  logic          w_pop;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_count = r_count;
  assign o_dout  = o_empty ? 8'h00 : r_mem[r_rptr];

  assign w_pop  = i_pop & ~o_empty;
  assign w_push = i_push & (~o_full | w_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (i_clr) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end

  // Storage needs no reset: nothing is visible until the count says so.
  always_ff @(posedge clk) begin
    if (w_push && !i_clr) r_mem[r_wptr] <= i_din;
  end

endmodule

// File: rtl/dl11_fifo_bridge.sv
// Multi-channel DL11-style register bank: DCJ11 side sees RCSR/RBUF/XCSR/XBUF per channel,
// Apple II side sees STAT/TXD/RXD/LVL; each direction is buffered by a byte_fifo.
module dl11_fifo_bridge
  import dl11_pkg::*;
#(
  parameter int          NCHAN      = 1,
  parameter int          FIFO_DEPTH = 16,
  parameter logic [21:0] CONS_BASE  = 22'o17777560,
  parameter logic [21:0] EXT_BASE   = 22'o17776500
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_cpu_init,
  input  logic [21:0]      i_cpu_addr,
  input  logic             i_cpu_rd,
  input  logic             i_cpu_wr,
  input  logic             i_cpu_byte,
  input  logic [15:0]      i_cpu_wdata,
  output logic [15:0]      o_cpu_rdata,
  output logic             o_cpu_hit,
  input  logic             i_a2_strb,
  input  logic             i_a2_rw,
  input  logic [3:0]       i_a2_addr,
  input  logic [7:0]       i_a2_wdata,
  output logic [7:0]       o_a2_rdata,
  output logic [NCHAN-1:0] o_rx_irq,
  output logic [NCHAN-1:0] o_tx_irq
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [1:0]       w_cpu_reg;
  logic [1:0]       w_a2_reg;
  logic [1:0]       w_a2_ch;
  logic [NCHAN-1:0] w_hit;
  logic [NCHAN-1:0] w_rx_empty, w_rx_full, w_tx_empty, w_tx_full;
  logic [NCHAN-1:0] w_rie, w_xie, w_ovr;
  logic [7:0]       w_rx_dout [NCHAN];
  logic [7:0]       w_tx_dout [NCHAN];
  logic [7:0]       w_tx_lvl  [NCHAN];
  logic [7:0]       w_a2_next;
  logic [7:0]       r_a2_rdata;
  logic             w_unused_wdata;

  assign w_cpu_reg      = i_cpu_addr[2:1];
  assign w_a2_reg       = i_a2_addr[1:0];
  assign w_a2_ch        = i_a2_addr[3:2];
  assign w_unused_wdata = ^i_cpu_wdata[15:8];

  for (genvar n = 0; n < NCHAN; n++) begin : g_chan
    localparam logic [21:0] BASE = chan_base(n, CONS_BASE, EXT_BASE);

    logic          w_rbuf_rd, w_xbuf_wr, w_ie_wr, w_rcsr_wr, w_xcsr_wr;
    logic          w_a2_sel, w_rxd_wr, w_txd_rd, w_rx_drop;
    logic [CW-1:0] w_rx_count, w_tx_count;
    logic [8:0]    w_lvl_ext;
    logic          w_unused_rx;
    logic          r_rie, r_xie, r_ovr, r_rx_irq, r_tx_irq;

    assign w_hit[n]  = (i_cpu_addr[21:3] == BASE[21:3]);
    assign w_rbuf_rd = i_cpu_rd & w_hit[n] & (w_cpu_reg == CPU_RBUF);
    assign w_xbuf_wr = i_cpu_wr & w_hit[n] & (w_cpu_reg == CPU_XBUF);
    // A byte write to the odd (high) byte cannot reach bit 6.
    assign w_ie_wr   = i_cpu_wr & w_hit[n] & (~i_cpu_byte | ~i_cpu_addr[0]);
    assign w_rcsr_wr = w_ie_wr & (w_cpu_reg == CPU_RCSR);
    assign w_xcsr_wr = w_ie_wr & (w_cpu_reg == CPU_XCSR);

    assign w_a2_sel  = i_a2_strb & (w_a2_ch == 2'(n));
    assign w_rxd_wr  = w_a2_sel & ~i_a2_rw & (w_a2_reg == A2_RXD);
    assign w_txd_rd  = w_a2_sel &  i_a2_rw & (w_a2_reg == A2_TXD);
    assign w_rx_drop = w_rxd_wr & w_rx_full[n] & ~w_rbuf_rd;

    byte_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_clr   (i_cpu_init),
      .i_push  (w_rxd_wr),
      .i_din   (i_a2_wdata),
      .i_pop   (w_rbuf_rd),
      .o_dout  (w_rx_dout[n]),
      .o_empty (w_rx_empty[n]),
      .o_full  (w_rx_full[n]),
      .o_count (w_rx_count)
    );

    byte_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_clr   (i_cpu_init),
      .i_push  (w_xbuf_wr),
      .i_din   (i_cpu_wdata[7:0]),
      .i_pop   (w_txd_rd),
      .o_dout  (w_tx_dout[n]),
      .o_empty (w_tx_empty[n]),
      .o_full  (w_tx_full[n]),
      .o_count (w_tx_count)
    );

    assign w_unused_rx = ^w_rx_count;
    assign w_lvl_ext   = 9'(w_tx_count);
    assign w_tx_lvl[n] = w_lvl_ext[8] ? 8'hFF : w_lvl_ext[7:0];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_rie    <= 1'b0;
        r_xie    <= 1'b0;
        r_ovr    <= 1'b0;
        r_rx_irq <= 1'b0;
        r_tx_irq <= 1'b0;
      end else if (i_cpu_init) begin
        r_rie    <= 1'b0;
        r_xie    <= 1'b0;
        r_ovr    <= 1'b0;
        r_rx_irq <= 1'b0;
        r_tx_irq <= 1'b0;
      end else begin
        if (w_rcsr_wr) r_rie <= i_cpu_wdata[BIT_IE];
        if (w_xcsr_wr) r_xie <= i_cpu_wdata[BIT_IE];
        if (w_rx_drop)      r_ovr <= 1'b1;
        else if (w_rbuf_rd) r_ovr <= 1'b0;
        r_rx_irq <= r_rie & ~w_rx_empty[n];
        r_tx_irq <= r_xie & ~w_tx_full[n];
      end
    end

    assign w_rie[n]    = r_rie;
    assign w_xie[n]    = r_xie;
    assign w_ovr[n]    = r_ovr;
    assign o_rx_irq[n] = r_rx_irq;
    assign o_tx_irq[n] = r_tx_irq;
  end

  always_comb begin
    o_cpu_hit   = 1'b0;
    o_cpu_rdata = 16'h0000;
    for (int n = 0; n < NCHAN; n++) begin
      if (w_hit[n]) begin
        o_cpu_hit = 1'b1;
        case (w_cpu_reg)
          CPU_RCSR: begin
            o_cpu_rdata[BIT_DONE] = ~w_rx_empty[n];
            o_cpu_rdata[BIT_IE]   = w_rie[n];
          end
          CPU_RBUF: begin
            o_cpu_rdata[BIT_ERR]  = w_ovr[n];
            o_cpu_rdata[BIT_OVR]  = w_ovr[n];
            o_cpu_rdata[7:0]      = w_rx_dout[n];
          end
          CPU_XCSR: begin
            o_cpu_rdata[BIT_READY] = ~w_tx_full[n];
            o_cpu_rdata[BIT_IE]    = w_xie[n];
          end
          default: o_cpu_rdata = 16'h0000;
        endcase
      end
    end
  end

  always_comb begin
    w_a2_next = 8'h00;
    for (int n = 0; n < NCHAN; n++) begin
      if (w_a2_ch == 2'(n)) begin
        case (w_a2_reg)
          A2_STAT: w_a2_next = {~w_tx_empty[n], w_rx_full[n], w_ovr[n], 5'b0};
          A2_TXD:  w_a2_next = w_tx_dout[n];
          A2_LVL:  w_a2_next = w_tx_lvl[n];
          default: w_a2_next = 8'h00;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   r_a2_rdata <= 8'h00;
    else if (i_cpu_init)          r_a2_rdata <= 8'h00;
    else if (i_a2_strb && i_a2_rw) r_a2_rdata <= w_a2_next;
  end

  assign o_a2_rdata = r_a2_rdata;

endmodule

// File: tb/tb_dl11_fifo_bridge.sv
// Directed bench for dl11_fifo_bridge (two channels, depth 16): each task drives one scenario
// and compares against hand-computed values.
module tb_dl11_fifo_bridge;

  localparam logic [21:0] RCSR0  = 22'o17777560;
  localparam logic [21:0] RBUF0  = 22'o17777562;
  localparam logic [21:0] XCSR0  = 22'o17777564;
  localparam logic [21:0] XCSR0H = 22'o17777565;
  localparam logic [21:0] XBUF0  = 22'o17777566;
  localparam logic [21:0] RCSR1  = 22'o17776500;
  localparam logic [21:0] RBUF1  = 22'o17776502;
  localparam logic [21:0] XBUF1  = 22'o17776506;
  localparam logic [21:0] NOCH2  = 22'o17776510;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_cpu_init, i_cpu_rd, i_cpu_wr, i_cpu_byte;
  logic [21:0] i_cpu_addr;
  logic [15:0] i_cpu_wdata;
  logic [15:0] o_cpu_rdata;
  logic        o_cpu_hit;
  logic        i_a2_strb, i_a2_rw;
  logic [3:0]  i_a2_addr;
  logic [7:0]  i_a2_wdata, o_a2_rdata;
  logic [1:0]  o_rx_irq, o_tx_irq;

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] d16;
  logic [7:0]  d8;
  logic        h;

  always #5 clk = ~clk;

  dl11_fifo_bridge #(.NCHAN(2), .FIFO_DEPTH(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_cpu_init  (i_cpu_init),
    .i_cpu_addr  (i_cpu_addr),
    .i_cpu_rd    (i_cpu_rd),
    .i_cpu_wr    (i_cpu_wr),
    .i_cpu_byte  (i_cpu_byte),
    .i_cpu_wdata (i_cpu_wdata),
    .o_cpu_rdata (o_cpu_rdata),
    .o_cpu_hit   (o_cpu_hit),
    .i_a2_strb   (i_a2_strb),
    .i_a2_rw     (i_a2_rw),
    .i_a2_addr   (i_a2_addr),
    .i_a2_wdata  (i_a2_wdata),
    .o_a2_rdata  (o_a2_rdata),
    .o_rx_irq    (o_rx_irq),
    .o_tx_irq    (o_tx_irq)
  );

  task automatic cpu_peek(input logic [21:0] a, output logic [15:0] d, output logic hit);
    @(negedge clk);
    i_cpu_addr = a;
    #1;
    d   = o_cpu_rdata;
    hit = o_cpu_hit;
  endtask

  task automatic cpu_read(input logic [21:0] a, output logic [15:0] d);
    @(negedge clk);
    i_cpu_addr = a;
    i_cpu_rd   = 1'b1;
    #1;
    d = o_cpu_rdata;
    @(negedge clk);
    i_cpu_rd = 1'b0;
  endtask

  task automatic cpu_write(input logic [21:0] a, input logic [15:0] d, input logic b);
    @(negedge clk);
    i_cpu_addr  = a;
    i_cpu_wdata = d;
    i_cpu_byte  = b;
    i_cpu_wr    = 1'b1;
    @(negedge clk);
    i_cpu_wr   = 1'b0;
    i_cpu_byte = 1'b0;
  endtask

  task automatic a2_write(input logic [1:0] ch, input logic [1:0] rg, input logic [7:0] d);
    @(negedge clk);
    i_a2_addr  = {ch, rg};
    i_a2_wdata = d;
    i_a2_rw    = 1'b0;
    i_a2_strb  = 1'b1;
    @(negedge clk);
    i_a2_strb = 1'b0;
  endtask

  task automatic a2_read(input logic [1:0] ch, input logic [1:0] rg, output logic [7:0] d);
    @(negedge clk);
    i_a2_addr = {ch, rg};
    i_a2_rw   = 1'b1;
    i_a2_strb = 1'b1;
    @(negedge clk);
    i_a2_strb = 1'b0;
    d = o_a2_rdata;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    cpu_peek(RCSR0, d16, h);
    n_cmp++; if (d16 !== 16'o0 || h !== 1'b1) begin n_bad++; $display("FAIL reset_rcsr got %h hit %b want 0000 hit 1", d16, h); end
    cpu_peek(XCSR0, d16, h);
    n_cmp++; if (d16 !== 16'o200) begin n_bad++; $display("FAIL reset_xcsr got %o want 200", d16); end
    n_cmp++; if (o_rx_irq !== 2'b00 || o_tx_irq !== 2'b00) begin n_bad++; $display("FAIL reset_irq got rx %b tx %b want 00 00", o_rx_irq, o_tx_irq); end
    n_cmp++; if (o_a2_rdata !== 8'h00) begin n_bad++; $display("FAIL reset_a2_rdata got %h want 00", o_a2_rdata); end
    a2_read(2'd0, 2'd0, d8);
    n_cmp++; if (d8 !== 8'h00) begin n_bad++; $display("FAIL reset_stat got %h want 00", d8); end
  endtask

  task automatic test_apple_rx();
    a2_write(2'd0, 2'd2, 8'h41);
    a2_write(2'd0, 2'd2, 8'h42);
    cpu_peek(RCSR0, d16, h);
    n_cmp++; if (d16 !== 16'o200) begin n_bad++; $display("FAIL rx_rcsr_done got %o want 200", d16); end
    cpu_read(RBUF0, d16);
    n_cmp++; if (d16 !== 16'h0041) begin n_bad++; $display("FAIL rx_rbuf_first got %h want 0041", d16); end
    cpu_read(RBUF0, d16);
    n_cmp++; if (d16 !== 16'h0042) begin n_bad++; $display("FAIL rx_rbuf_second got %h want 0042", d16); end
    cpu_peek(RCSR0, d16, h);
    n_cmp++; if (d16 !== 16'o0) begin n_bad++; $display("FAIL rx_rcsr_empty got %o want 0", d16); end
    cpu_read(RBUF0, d16);
    n_cmp++; if (d16 !== 16'h0000) begin n_bad++; $display("FAIL rx_rbuf_empty got %h want 0000", d16); end
  endtask

  task automatic test_overrun();
    for (int i = 0; i < 17; i++) a2_write(2'd0, 2'd2, 8'(8'h10 + i));
    a2_read(2'd0, 2'd0, d8);
    n_cmp++; if (d8 !== 8'h60) begin n_bad++; $display("FAIL ovr_stat got %h want 60", d8); end
    cpu_read(RBUF0, d16);
    n_cmp++; if (d16 !== 16'o140020) begin n_bad++; $display("FAIL ovr_rbuf got %o want 140020", d16); end
    cpu_peek(RBUF0, d16, h);
    n_cmp++; if (d16 !== 16'h0011) begin n_bad++; $display("FAIL ovr_cleared got %h want 0011", d16); end
    for (int i = 0; i < 15; i++) begin
      cpu_read(RBUF0, d16);
      n_cmp++; if (d16 !== 16'(8'h11 + i)) begin n_bad++; $display("FAIL ovr_drain[%0d] got %h want %h", i, d16, 16'(8'h11 + i)); end
    end
    a2_read(2'd0, 2'd0, d8);
    n_cmp++; if (d8 !== 8'h00) begin n_bad++; $display("FAIL ovr_stat_after got %h want 00", d8); end
  endtask

  task automatic test_tx_full();
    for (int i = 0; i < 16; i++) cpu_write(XBUF0, 16'hFF00 | 16'(8'hA0 + i), 1'b0);
    cpu_peek(XCSR0, d16, h);
    n_cmp++; if (d16 !== 16'o0) begin n_bad++; $display("FAIL txf_xcsr got %o want 0", d16); end
    a2_read(2'd0, 2'd3, d8);
    n_cmp++; if (d8 !== 8'd16) begin n_bad++; $display("FAIL txf_lvl got %0d want 16", d8); end
    a2_read(2'd0, 2'd0, d8);
    n_cmp++; if (d8 !== 8'h80) begin n_bad++; $display("FAIL txf_stat got %h want 80", d8); end
    a2_read(2'd0, 2'd1, d8);
    n_cmp++; if (d8 !== 8'hA0) begin n_bad++; $display("FAIL txf_pop got %h want a0", d8); end
    cpu_peek(XCSR0, d16, h);
    n_cmp++; if (d16 !== 16'o200) begin n_bad++; $display("FAIL txf_ready got %o want 200", d16); end
  endtask

  task automatic test_back_to_back();
    cpu_write(XBUF0, 16'h00B0, 1'b0);
    @(negedge clk);
    i_cpu_addr  = XBUF0;
    i_cpu_wdata = 16'h00B1;
    i_cpu_wr    = 1'b1;
    i_a2_addr   = 4'b0001;
    i_a2_rw     = 1'b1;
    i_a2_strb   = 1'b1;
    @(negedge clk);
    i_cpu_wr  = 1'b0;
    i_a2_strb = 1'b0;
    n_cmp++; if (o_a2_rdata !== 8'hA1) begin n_bad++; $display("FAIL b2b_pop got %h want a1", o_a2_rdata); end
    a2_read(2'd0, 2'd3, d8);
    n_cmp++; if (d8 !== 8'd16) begin n_bad++; $display("FAIL b2b_lvl got %0d want 16", d8); end
    cpu_write(XCSR0H, 16'hFFFF, 1'b1);
    cpu_peek(XCSR0, d16, h);
    n_cmp++; if (d16 !== 16'o0) begin n_bad++; $display("FAIL ie_hibyte got %o want 0", d16); end
    cpu_write(XCSR0, 16'o100, 1'b0);
    cpu_peek(XCSR0, d16, h);
    n_cmp++; if (d16 !== 16'o100) begin n_bad++; $display("FAIL ie_word got %o want 100", d16); end
    n_cmp++; if (o_tx_irq !== 2'b00) begin n_bad++; $display("FAIL txirq_full got %b want 00", o_tx_irq); end
    a2_read(2'd0, 2'd1, d8);
    n_cmp++; if (d8 !== 8'hA2) begin n_bad++; $display("FAIL b2b_pop2 got %h want a2", d8); end
    @(negedge clk);
    n_cmp++; if (o_tx_irq !== 2'b01) begin n_bad++; $display("FAIL txirq_ready got %b want 01", o_tx_irq); end
    cpu_write(XCSR0H, 16'h0000, 1'b1);
    cpu_peek(XCSR0, d16, h);
    n_cmp++; if (d16 !== 16'o300) begin n_bad++; $display("FAIL ie_hibyte_keep got %o want 300", d16); end
  endtask

  task automatic test_channels();
    bit seen;
    cpu_write(RCSR1, 16'o100, 1'b0);
    cpu_peek(RCSR1, d16, h);
    n_cmp++; if (d16 !== 16'o100) begin n_bad++; $display("FAIL ch1_rie got %o want 100", d16); end
    a2_write(2'd1, 2'd2, 8'h55);
    seen = 1'b0;
    for (int k = 0; k < 3 && !seen; k++) begin
      if (o_rx_irq === 2'b10) seen = 1'b1;
      else @(negedge clk);
    end
    n_cmp++; if (!seen) begin n_bad++; $display("FAIL ch1_rxirq got %b want 10", o_rx_irq); end
    n_cmp++; if (o_tx_irq !== 2'b01) begin n_bad++; $display("FAIL ch_txirq got %b want 01", o_tx_irq); end
    cpu_peek(RBUF1, d16, h);
    n_cmp++; if (d16 !== 16'h0055) begin n_bad++; $display("FAIL ch1_rbuf got %h want 0055", d16); end
    cpu_peek(XBUF1, d16, h);
    n_cmp++; if (h !== 1'b1 || d16 !== 16'h0000) begin n_bad++; $display("FAIL ch1_xbuf got %h hit %b want 0000 hit 1", d16, h); end
    cpu_peek(NOCH2, d16, h);
    n_cmp++; if (h !== 1'b0 || d16 !== 16'h0000) begin n_bad++; $display("FAIL ch2_nohit got hit %b data %h want 0 0000", h, d16); end
    a2_read(2'd0, 2'd3, d8);
    n_cmp++; if (d8 !== 8'd15) begin n_bad++; $display("FAIL ch0_lvl got %0d want 15", d8); end
    a2_read(2'd2, 2'd0, d8);
    n_cmp++; if (d8 !== 8'h00) begin n_bad++; $display("FAIL ch2_a2 got %h want 00", d8); end
  endtask

  task automatic test_init();
    a2_write(2'd0, 2'd2, 8'h33);
    a2_read(2'd0, 2'd3, d8);
    n_cmp++; if (d8 !== 8'd15) begin n_bad++; $display("FAIL init_pre_lvl got %0d want 15", d8); end
    @(negedge clk);
    i_cpu_init  = 1'b1;
    i_a2_addr   = 4'b0010;
    i_a2_wdata  = 8'h77;
    i_a2_rw     = 1'b0;
    i_a2_strb   = 1'b1;
    i_cpu_addr  = XBUF0;
    i_cpu_wdata = 16'h0099;
    i_cpu_wr    = 1'b1;
    @(negedge clk);
    i_cpu_init = 1'b0;
    i_a2_strb  = 1'b0;
    i_cpu_wr   = 1'b0;
    n_cmp++; if (o_a2_rdata !== 8'h00) begin n_bad++; $display("FAIL init_a2_rdata got %h want 00", o_a2_rdata); end
    cpu_peek(RCSR0, d16, h);
    n_cmp++; if (d16 !== 16'o0) begin n_bad++; $display("FAIL init_rcsr0 got %o want 0", d16); end
    cpu_peek(XCSR0, d16, h);
    n_cmp++; if (d16 !== 16'o200) begin n_bad++; $display("FAIL init_xcsr0 got %o want 200", d16); end
    cpu_peek(RCSR1, d16, h);
    n_cmp++; if (d16 !== 16'o0) begin n_bad++; $display("FAIL init_rcsr1 got %o want 0", d16); end
    n_cmp++; if (o_rx_irq !== 2'b00 || o_tx_irq !== 2'b00) begin n_bad++; $display("FAIL init_irq got rx %b tx %b want 00 00", o_rx_irq, o_tx_irq); end
    a2_read(2'd0, 2'd3, d8);
    n_cmp++; if (d8 !== 8'd0) begin n_bad++; $display("FAIL init_lvl got %0d want 0", d8); end
    a2_read(2'd0, 2'd0, d8);
    n_cmp++; if (d8 !== 8'h00) begin n_bad++; $display("FAIL init_stat got %h want 00", d8); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n       = 1'b0;
    i_cpu_init  = 1'b0;
    i_cpu_rd    = 1'b0;
    i_cpu_wr    = 1'b0;
    i_cpu_byte  = 1'b0;
    i_cpu_addr  = '0;
    i_cpu_wdata = '0;
    i_a2_strb   = 1'b0;
    i_a2_rw     = 1'b0;
    i_a2_addr   = '0;
    i_a2_wdata  = '0;
    test_reset();
    test_apple_rx();
    test_overrun();
    test_tx_full();
    test_back_to_back();
    test_channels();
    test_init();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
